// File: rtl/adap_quan_seq.sv
// rtl/adap_quan_seq.sv - G.726 encoder adaptive quantizer (LOG, SUBTB, QUAN) with a sequential threshold search
// Build option: define ADAP_QUAN_BINSRCH_EN for a fixed-length binary search; default is a linear search.
module adap_quan_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        START,
    input  logic [15:0] D,
    input  logic [12:0] Y,
    input  logic [1:0]  RATE,
    output logic        BUSY,
    output logic        VALID,
    output logic [4:0]  I
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOG, ST_SRCH, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic [15:0]        d_q, d_d;
    logic [12:0]        y_q, y_d;
    logic [1:0]         rate_q, rate_d;
    logic signed [11:0] dln_q, dln_d;
    logic [4:0]         i_q, i_d;
`ifdef ADAP_QUAN_BINSRCH_EN
    logic [3:0]         acc_q, acc_d;
    logic [3:0]         step_q, step_d;
    logic [3:0]         step_init;
    logic [3:0]         probe;
    logic [3:0]         acc_next;
`else
    logic [3:0]         k_q, k_d;
    logic               below;
`endif

    logic [15:0]        d_abs;
    logic [14:0]        dqm;
    logic [3:0]         exp_v;
    logic [6:0]         mant;
    logic [10:0]        dl;
    logic signed [11:0] dln_calc;
    logic [3:0]         n_val;
    logic               srch_exit;
    logic [3:0]         srch_i;
    logic [4:0]         cw;
    logic               unused_y_lsbs;

    // Decision levels in the log domain, ascending, one table per rate
    function automatic logic signed [11:0] thr(input logic [1:0] r, input logic [3:0] k);
        logic signed [11:0] t;
        t = 12'sd0;
        case (r)
            2'd0: begin
                case (k)
                    4'd0:    t = -12'sd122;
                    4'd1:    t = -12'sd16;
                    4'd2:    t = 12'sd68;
                    4'd3:    t = 12'sd139;
                    4'd4:    t = 12'sd198;
                    4'd5:    t = 12'sd250;
                    4'd6:    t = 12'sd298;
                    4'd7:    t = 12'sd339;
                    4'd8:    t = 12'sd378;
                    4'd9:    t = 12'sd413;
                    4'd10:   t = 12'sd445;
                    4'd11:   t = 12'sd475;
                    4'd12:   t = 12'sd502;
                    4'd13:   t = 12'sd526;
                    4'd14:   t = 12'sd549;
                    default: t = 12'sd0;
                endcase
            end
            2'd1: begin
                case (k)
                    4'd0:    t = -12'sd124;
                    4'd1:    t = 12'sd80;
                    4'd2:    t = 12'sd178;
                    4'd3:    t = 12'sd246;
                    4'd4:    t = 12'sd300;
                    4'd5:    t = 12'sd349;
                    4'd6:    t = 12'sd400;
                    default: t = 12'sd0;
                endcase
            end
            2'd2: begin
                case (k)
                    4'd0:    t = 12'sd8;
                    4'd1:    t = 12'sd218;
                    4'd2:    t = 12'sd331;
                    default: t = 12'sd0;
                endcase
            end
            default: begin
                case (k)
                    4'd0:    t = 12'sd261;
                    default: t = 12'sd0;
                endcase
            end
        endcase
        return t;
    endfunction

    // Number of decision levels for the selected rate
    function automatic logic [3:0] n_of(input logic [1:0] r);
        case (r)
            2'd0:    return 4'd15;
            2'd1:    return 4'd7;
            2'd2:    return 4'd3;
            default: return 4'd1;
        endcase
    endfunction

    // The two low Y bits drop out of Y>>2
    assign unused_y_lsbs = ^y_q[1:0];

    // LOG and SUBTB: magnitude, log2 approximation and scale-factor subtraction
    always_comb begin
        d_abs = d_q[15] ? (~d_q + 16'd1) : d_q;
        dqm   = d_abs[15] ? 15'h7FFF : d_abs[14:0];
        exp_v = 4'd0;
        for (int b = 0; b < 15; b++) begin
            if (dqm[b]) exp_v = 4'(b);
        end
        mant     = 7'({dqm, 7'b0} >> exp_v);
        dl       = {exp_v, mant};
        dln_calc = $signed({1'b0, dl} - {1'b0, y_q[12:2]});
    end

    // QUAN: one threshold compare per SRCH cycle, then codeword mapping
    always_comb begin
        n_val = n_of(rate_q);
`ifdef ADAP_QUAN_BINSRCH_EN
        case (rate_q)
            2'd0:    step_init = 4'd8;
            2'd1:    step_init = 4'd4;
            2'd2:    step_init = 4'd2;
            default: step_init = 4'd1;
        endcase
        probe     = acc_q + step_q - 4'd1;
        acc_next  = (dln_q >= thr(rate_q, probe)) ? (acc_q + step_q) : acc_q;
        srch_exit = (step_q == 4'd1);
        srch_i    = acc_next;
`else
        below     = (dln_q < thr(rate_q, k_q));
        srch_exit = below || (k_q == n_val - 4'd1);
        srch_i    = below ? k_q : n_val;
`endif
        if (d_q[15]) begin
            cw = {n_val, 1'b1} - {1'b0, srch_i};
        end else if (srch_i == 4'd0) begin
            cw = {n_val, 1'b1};
        end else begin
            cw = {1'b0, srch_i};
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (START) state_d = ST_LOG;
            ST_LOG:  state_d = ST_SRCH;
            ST_SRCH: if (srch_exit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: capture inputs, latch DLN, step the search, latch the codeword
    always_comb begin
        d_d    = d_q;
        y_d    = y_q;
        rate_d = rate_q;
        dln_d  = dln_q;
        i_d    = i_q;
`ifdef ADAP_QUAN_BINSRCH_EN
        acc_d  = acc_q;
        step_d = step_q;
`else
        k_d    = k_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    d_d    = D;
                    y_d    = Y;
                    rate_d = RATE;
                end
            end
            ST_LOG: begin
                dln_d = dln_calc;
`ifdef ADAP_QUAN_BINSRCH_EN
                acc_d  = 4'd0;
                step_d = step_init;
`else
                k_d = 4'd0;
`endif
            end
            ST_SRCH: begin
                if (srch_exit) i_d = cw;
`ifdef ADAP_QUAN_BINSRCH_EN
                acc_d  = acc_next;
                step_d = step_q >> 1;
`else
                if (!srch_exit) k_d = k_q + 4'd1;
`endif
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q    <= '0;
            y_q    <= '0;
            rate_q <= '0;
            dln_q  <= '0;
            i_q    <= '0;
`ifdef ADAP_QUAN_BINSRCH_EN
            acc_q  <= '0;
            step_q <= '0;
`else
            k_q    <= '0;
`endif
        end else begin
            d_q    <= d_d;
            y_q    <= y_d;
            rate_q <= rate_d;
            dln_q  <= dln_d;
            i_q    <= i_d;
`ifdef ADAP_QUAN_BINSRCH_EN
            acc_q  <= acc_d;
            step_q <= step_d;
`else
            k_q    <= k_d;
`endif
        end
    end

    // Outputs decoded from state; I is the held codeword register
    always_comb begin
        BUSY  = (state_q != ST_IDLE);
        VALID = (state_q == ST_DONE);
        I     = i_q;
    end

endmodule

// File: tb/tb_adap_quan_seq.sv
// tb/tb_adap_quan_seq.sv - scoreboard bench for adap_quan_seq against a G.726 quantizer model
module tb_adap_quan_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        START;
    logic [15:0] D;
    logic [12:0] Y;
    logic [1:0]  RATE;
    logic        BUSY;
    logic        VALID;
    logic [4:0]  I;

    always #5 clk = ~clk;

    adap_quan_seq dut (
        .clk   (clk),
        .reset (reset),
        .START (START),
        .D     (D),
        .Y     (Y),
        .RATE  (RATE),
        .BUSY  (BUSY),
        .VALID (VALID),
        .I     (I)
    );

    typedef struct {
        int cw;
        int lat;
        int start;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // G.726 quantize(): log of |d|, subtract y>>2, count decision levels not above dln
    function automatic void ref_model(input logic [15:0] d, input logic [12:0] y,
                                      input logic [1:0] rate, output int cw, output int lat);
        int tbl[$];
        int sv, dqm, ex, mant, dl, dln, n, i;
        case (rate)
            2'd0: tbl = '{-122, -16, 68, 139, 198, 250, 298, 339, 378, 413, 445, 475, 502, 526, 549};
            2'd1: tbl = '{-124, 80, 178, 246, 300, 349, 400};
            2'd2: tbl = '{8, 218, 331};
            default: tbl = '{261};
        endcase
        n   = tbl.size();
        sv  = int'($signed(d));
        dqm = (sv < 0) ? -sv : sv;
        if (dqm > 32767) dqm = 32767;
        ex = 0;
        while ((dqm >> (ex + 1)) != 0) ex++;
        mant = ((dqm << 7) >> ex) & 127;
        dl   = ex * 128 + mant;
        dln  = dl - (int'(y) / 4);
        i = 0;
        while (i < n && dln >= tbl[i]) i++;
        if (sv < 0)      cw = 2 * n + 1 - i;
        else if (i == 0) cw = 2 * n + 1;
        else             cw = i;
`ifdef ADAP_QUAN_BINSRCH_EN
        lat = 2 + $clog2(n + 1);
`else
        lat = 2 + ((i < n) ? i + 1 : n);
`endif
    endfunction

    // Monitor: every VALID must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (VALID) begin
            if (sb.size() == 0) begin
                check("valid_with_empty_scoreboard", int'(VALID), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("codeword", int'(I), e.cw);
                check("latency", cyc - e.start, e.lat);
            end
        end
    end

    // Called at #1 after a posedge with the DUT idle; returns at #1 of the first idle cycle
    task automatic do_txn(input logic [15:0] d, input logic [12:0] y, input logic [1:0] rate, input bit flood);
        exp_t e;
        START = 1'b1;
        D     = d;
        Y     = y;
        RATE  = rate;
        ref_model(d, y, rate, e.cw, e.lat);
        e.start = cyc;
        sb.push_back(e);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) break;
            check("busy_in_flight", int'(BUSY), 1);
            if (flood) begin
                START = 1'b1;
                D     = 16'($urandom);
                Y     = 13'($urandom);
                RATE  = 2'($urandom);
            end else begin
                START = 1'b0;
            end
        end
        START = 1'b0;
        if (sb.size() != 0) begin
            check("txn_timeout_pending", sb.size(), 0);
            sb.delete();
        end else begin
            check("busy_after_done", int'(BUSY), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        START = 1'b0;
        D     = '0;
        Y     = '0;
        RATE  = '0;
        #2;
        check("reset_busy", int'(BUSY), 0);
        check("reset_valid", int'(VALID), 0);
        check("reset_i", int'(I), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors
        do_txn(16'h0000, 13'd544, 2'd1, 1'b0);
        do_txn(16'h7FFF, 13'd544, 2'd1, 1'b0);
        do_txn(16'h8001, 13'd544, 2'd1, 1'b0);
        do_txn(16'h7FFF, 13'd544, 2'd0, 1'b0);
        do_txn(16'h8001, 13'd544, 2'd0, 1'b1);
        do_txn(16'h8000, 13'd0,   2'd2, 1'b0);
        do_txn(16'h8000, 13'd0,   2'd3, 1'b0);
        do_txn(16'h0001, 13'd8191, 2'd3, 1'b0);
        do_txn(16'h0000, 13'd8191, 2'd0, 1'b1);
        do_txn(16'hFFFF, 13'd2048, 2'd2, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 400; t++) begin
            logic [12:0] yy;
            if ($urandom_range(1, 0) == 1) yy = 13'($urandom);
            else                           yy = 13'($urandom_range(5120, 544));
            do_txn(16'($urandom), yy, 2'($urandom), ($urandom_range(3, 0) == 0));
        end

        // Abort mid-search with reset
        do_txn(16'h7FFF, 13'd544, 2'd0, 1'b0);
        check("i_before_abort", int'(I), 15);
        START = 1'b1;
        D     = 16'h7FFF;
        Y     = 13'd544;
        RATE  = 2'd0;
        @(posedge clk);
        #1;
        START = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("abort_busy", int'(BUSY), 0);
        check("abort_valid", int'(VALID), 0);
        check("abort_i", int'(I), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("idle_after_abort", int'(BUSY), 0);
        do_txn(16'h8001, 13'd544, 2'd1, 1'b0);
        do_txn(16'h1234, 13'd1000, 2'd0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
